// File: rtl/gpio_in_debounce_irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_debounce_irq_pkg : register map shared by the GPIO input tile |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package gpio_in_debounce_irq_pkg;

    localparam int GPIO_AW = 2;

    localparam logic [GPIO_AW-1:0] GPIO_DATA_ADDR = 2'd0;
    localparam logic [GPIO_AW-1:0] GPIO_MASK_ADDR = 2'd1;
    localparam logic [GPIO_AW-1:0] GPIO_EDGE_ADDR = 2'd2;
    localparam logic [GPIO_AW-1:0] GPIO_PEND_ADDR = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_debounce_bit : 2-flop synchroniser, debounce counter, edge pulse |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module gpio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic INIT_BIT        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_update;

    assign w_diff   = r_sync ^ r_stable;
    assign w_update = w_diff && (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= INIT_BIT;
            r_sync   <= INIT_BIT;
            r_stable <= INIT_BIT;
            r_cnt    <= '0;
        end else begin
            r_meta <= pin;
            r_sync <= r_meta;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_update) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Pulses mark the cycle whose closing edge loads the new stable value
    assign stable = r_stable;
    assign rise   = w_update & r_sync;
    assign fall   = w_update & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/gpio_in_debounce_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_in_debounce_irq : debounced GPIO inputs, edge capture, IRQ, bus  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module gpio_in_debounce_irq
    import gpio_in_debounce_irq_pkg::*;
#(
    parameter int                    PORT_WIDTH      = 8,
    parameter int                    DEBOUNCE_CYCLES = 50000,
    parameter logic [PORT_WIDTH-1:0] INIT_VALUE      = '1,
    parameter int                    Dw              = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PORT_WIDTH-1:0] gpio_i,
    input  logic [Dw-1:0]         sa_dat_i,
    input  logic [GPIO_AW-1:0]    sa_addr_i,
    input  logic                  sa_stb_i,
    input  logic                  sa_cyc_i,
    input  logic                  sa_we_i,
    output logic [Dw-1:0]         sa_dat_o,
    output logic                  sa_ack_o,
    output logic                  irq_o
);

    logic [PORT_WIDTH-1:0] w_stable;
    logic [PORT_WIDTH-1:0] w_rise;
    logic [PORT_WIDTH-1:0] w_fall;
    logic [PORT_WIDTH-1:0] w_edge;
    logic [PORT_WIDTH-1:0] w_pend_clr;
    logic [PORT_WIDTH-1:0] w_wdata;
    logic [Dw-1:0]         w_rdata;
    logic                  w_access;
    logic                  w_write;

    logic [PORT_WIDTH-1:0] r_mask;
    logic [PORT_WIDTH-1:0] r_edge_sel;
    logic [PORT_WIDTH-1:0] r_pending;
    logic [Dw-1:0]         r_dat;
    logic                  r_ack;
    logic                  r_irq;

    for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_BIT        (INIT_VALUE[i])
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .pin    (gpio_i[i]),
            .stable (w_stable[i]),
            .rise   (w_rise[i]),
            .fall   (w_fall[i])
        );
    end

    if (PORT_WIDTH < Dw) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^sa_dat_i[Dw-1:PORT_WIDTH];
    end

    assign w_access   = sa_stb_i & sa_cyc_i & ~r_ack;
    assign w_write    = w_access & sa_we_i;
    assign w_wdata    = sa_dat_i[PORT_WIDTH-1:0];
    assign w_edge     = (w_rise & r_edge_sel) | (w_fall & ~r_edge_sel);
    assign w_pend_clr = (w_write && sa_addr_i == GPIO_PEND_ADDR) ? w_wdata : '0;

    always_comb begin
        w_rdata = '0;
        case (sa_addr_i)
            GPIO_DATA_ADDR: w_rdata[PORT_WIDTH-1:0] = w_stable;
            GPIO_MASK_ADDR: w_rdata[PORT_WIDTH-1:0] = r_mask;
            GPIO_EDGE_ADDR: w_rdata[PORT_WIDTH-1:0] = r_edge_sel;
            default:        w_rdata[PORT_WIDTH-1:0] = r_pending;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= '0;
            r_edge_sel <= '0;
            r_pending  <= '0;
            r_dat      <= '0;
            r_ack      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_ack <= w_access;
            r_dat <= w_access ? w_rdata : '0;
            if (w_write && sa_addr_i == GPIO_MASK_ADDR) begin
                r_mask <= w_wdata;
            end
            if (w_write && sa_addr_i == GPIO_EDGE_ADDR) begin
                r_edge_sel <= w_wdata;
            end
            // A fresh edge overrides a simultaneous write-1-to-clear
            r_pending <= (r_pending & ~w_pend_clr) | w_edge;
            r_irq     <= |(r_pending & r_mask);
        end
    end

    assign sa_dat_o = r_dat;
    assign sa_ack_o = r_ack;
    assign irq_o    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_debounce_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_in_debounce_irq : directed self-checking bench, 4-cycle debounce |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_gpio_in_debounce_irq;

    localparam int PW = 8;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  gpio_i;
    logic [31:0] sa_dat_i;
    logic [1:0]  sa_addr_i;
    logic        sa_stb_i;
    logic        sa_cyc_i;
    logic        sa_we_i;
    logic [31:0] sa_dat_o;
    logic        sa_ack_o;
    logic        irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    gpio_in_debounce_irq #(
        .PORT_WIDTH      (PW),
        .DEBOUNCE_CYCLES (DC),
        .INIT_VALUE      (8'hFF),
        .Dw              (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gpio_i    (gpio_i),
        .sa_dat_i  (sa_dat_i),
        .sa_addr_i (sa_addr_i),
        .sa_stb_i  (sa_stb_i),
        .sa_cyc_i  (sa_cyc_i),
        .sa_we_i   (sa_we_i),
        .sa_dat_o  (sa_dat_o),
        .sa_ack_o  (sa_ack_o),
        .irq_o     (irq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the ack cycle.
    task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic irq_at_ack);
        sa_stb_i  = 1'b1;
        sa_cyc_i  = 1'b1;
        sa_we_i   = we;
        sa_addr_i = addr;
        sa_dat_i  = wd;
        @(negedge clk);
        check("ack_one_cycle_after_stb", {31'd0, sa_ack_o}, 32'd1);
        rd         = sa_dat_o;
        irq_at_ack = irq_o;
        sa_stb_i = 1'b0;
        sa_cyc_i = 1'b0;
        sa_we_i  = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", {31'd0, sa_ack_o}, 32'd0);
        check("dat_zero_without_ack", sa_dat_o, 32'd0);
    endtask

    task automatic rd_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        q;
        bus(1'b0, addr, 32'd0, d, q);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic        q;
        bus(1'b1, addr, wd, d, q);
    endtask

    initial begin
        logic [31:0] d;
        logic        q;

        vecs[0] = '{1'b1, 2'd1, 32'h0000_00A5, 32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h0,         32'h0000_00A5};
        vecs[2] = '{1'b1, 2'd2, 32'h0000_003C, 32'h0};
        vecs[3] = '{1'b0, 2'd2, 32'h0,         32'h0000_003C};
        vecs[4] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0};
        vecs[5] = '{1'b0, 2'd0, 32'h0,         32'h0000_00FF};
        vecs[6] = '{1'b1, 2'd1, 32'hFFFF_FF00, 32'h0};
        vecs[7] = '{1'b0, 2'd1, 32'h0,         32'h0000_0000};

        reset     = 1'b1;
        gpio_i    = 8'hFF;
        sa_dat_i  = '0;
        sa_addr_i = '0;
        sa_stb_i  = 1'b0;
        sa_cyc_i  = 1'b0;
        sa_we_i   = 1'b0;
        step(3);
        check("reset_ack", {31'd0, sa_ack_o}, 32'd0);
        check("reset_dat", sa_dat_o, 32'd0);
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        reset = 1'b0;
        step(1);

        rd_check("reset_data_read", 2'd0, 32'h0000_00FF);
        check("reset_irq_after_read", {31'd0, irq_o}, 32'd0);

        // Held strobe: ack every other cycle
        sa_stb_i = 1'b1; sa_cyc_i = 1'b1; sa_we_i = 1'b0; sa_addr_i = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_stb_ack", {31'd0, sa_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
        step(1);

        for (int i = 0; i < 8; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, d, q);
            if (!vecs[i].we) check($sformatf("vec%0d_read", i), d, vecs[i].exp);
            check($sformatf("vec%0d_irq", i), {31'd0, irq_o}, 32'd0);
        end

        // Glitch of DC-1 cycles is ignored
        gpio_i[0] = 1'b0;
        step(DC - 1);
        gpio_i[0] = 1'b1;
        step(10);
        rd_check("glitch_data", 2'd0, 32'h0000_00FF);
        rd_check("glitch_pending", 2'd3, 32'h0);

        // Falling edge on bit 0: stable after 2+DC edges, irq one edge later
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h1);
        gpio_i[0] = 1'b0;
        step(2 + DC);
        check("irq_before_pending", {31'd0, irq_o}, 32'd0);
        step(1);
        check("irq_after_pending", {31'd0, irq_o}, 32'd1);
        rd_check("press_data", 2'd0, 32'h0000_00FE);
        rd_check("press_pending", 2'd3, 32'h0000_0001);

        wr(2'd3, 32'h1);
        check("irq_after_clear", {31'd0, irq_o}, 32'd0);
        rd_check("pending_cleared", 2'd3, 32'h0);

        // Rising edge not selected, then a new falling edge lands on the clear-ack edge
        gpio_i[0] = 1'b1;
        step(10);
        rd_check("release_no_pending", 2'd3, 32'h0);
        gpio_i[0] = 1'b0;
        step(1 + DC);
        wr(2'd3, 32'h1);
        rd_check("edge_beats_clear", 2'd3, 32'h0000_0001);
        wr(2'd3, 32'h1);
        rd_check("pending_cleared_again", 2'd3, 32'h0);

        // Pending bit 3 while masked, then unmask
        wr(2'd1, 32'h0);
        gpio_i[3] = 1'b0;
        step(10);
        check("masked_irq", {31'd0, irq_o}, 32'd0);
        rd_check("bit3_pending", 2'd3, 32'h0000_0008);
        bus(1'b1, 2'd1, 32'h8, d, q);
        check("irq_on_mask_ack", {31'd0, q}, 32'd0);
        check("irq_after_unmask", {31'd0, irq_o}, 32'd1);

        // Reset in the middle of a debounce and a strobe
        gpio_i[5] = 1'b0;
        step(3);
        sa_stb_i = 1'b1; sa_cyc_i = 1'b1; sa_we_i = 1'b0; sa_addr_i = 2'd3;
        reset = 1'b1;
        step(1);
        check("midreset_ack", {31'd0, sa_ack_o}, 32'd0);
        check("midreset_dat", sa_dat_o, 32'd0);
        check("midreset_irq", {31'd0, irq_o}, 32'd0);
        sa_stb_i = 1'b0; sa_cyc_i = 1'b0;
        gpio_i = 8'hFF;
        step(2);
        reset = 1'b0;
        step(10);
        check("post_reset_irq", {31'd0, irq_o}, 32'd0);
        rd_check("post_reset_pending", 2'd3, 32'h0);
        rd_check("post_reset_data", 2'd0, 32'h0000_00FF);
        rd_check("post_reset_mask", 2'd1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
